posit_to_fp_pipe: RTL and testbench
===================================

POSIT_TO_FP_PIPE -- requirements
Module: posit_to_fp_pipe

Interface
REQ-001 SHALL have parameter N, default 16, posit width and FP output width.
REQ-002 SHALL have parameter ES, default 2, posit exponent field width.
REQ-003 SHALL have parameter FE, default 5, FP exponent width; mantissa width FM = N-FE-1; bias = 2^(FE-1)-1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port in_posit, input, N, posit operand.
REQ-007 SHALL have port in_valid, input, 1, operand present.
REQ-008 SHALL have port in_ready, output, 1, operand accepted this cycle when in_valid & in_ready.
REQ-009 SHALL have port out_fp, output, N, FP result {sign, exp[FE], mant[FM]}.
REQ-010 SHALL have port out_flags, output, 5, {nar, zero, ovf, unf, inexact} (bit 4 down to 0).
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts when out_valid & out_ready.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 sign/two's-complement magnitude + regime/exponent/fraction decode; S2 unbiased scale = k*2^ES + e, add bias, align mantissa with guard/sticky; S3 round-to-nearest-even, range check, pack.
REQ-014 SHALL have latency exactly 3 cycles from accepted input to out_valid with no stall; throughput 1 per cycle.
REQ-015 SHALL stall elastically: stage advances iff next stage empty or advancing; in_ready = ~S1_valid | S1 advancing, combinational from out_ready, no bubbles inserted.
REQ-016 SHALL hold out_fp, out_flags, out_valid stable while out_valid & ~out_ready.
REQ-017 SHALL map posit 0 to +0 with zero=1, all other flags 0.
REQ-018 SHALL map NaR (1 followed by zeros) to canonical qNaN {0, all-ones exp, 1, zeros} with nar=1.
REQ-019 SHALL round fraction to FM bits by RNE; inexact=1 when any discarded bit nonzero; rounding carry increments exponent.
REQ-020 SHALL on biased exponent >= 2^FE-1 (after rounding) output signed infinity, ovf=1, inexact=1.
REQ-021 SHALL on biased exponent <= 0 flush to signed zero, unf=1, inexact=1 (no subnormals).
REQ-022 SHALL size internal scale arithmetic as signed, width max(FE, ES+clog2(N))+2, no wrap for any legal N/ES/FE.
REQ-023 SHALL accept and propagate simultaneous input accept and output retire in same cycle.

Reset
REQ-024 SHALL on rst_n low clear all stage valids asynchronously: out_valid=0, in_ready=1, out_fp=0, out_flags=0.
REQ-025 SHALL discard in-flight operands on reset mid-operation; first post-reset result appears 3 cycles after first accept.

Structure
REQ-026 SHALL place clog2 function, flag bit indices, and canonical qNaN/inf builders in shared package posit_fp_pkg.
REQ-027 SHALL instantiate one combinational sub-module posit_decode (N, ES) producing regime k, regime-sign, exponent, left-aligned fraction; used in S1.

Verification (N=16, ES=2, FE=5)
REQ-028 SHALL check 0x4000 -> 0x3C00 flags 0; 0xC000 -> 0xBC00 flags 0, each 3 cycles after accept.
REQ-029 SHALL check 0x0000 -> 0x0000 zero=1; 0x8000 -> 0x7E00 nar=1.
REQ-030 SHALL check 0x7FFF (2^56) -> 0x7C00 ovf+inexact; 0x0001 (2^-56) -> 0x0000 unf+inexact.
REQ-031 SHALL check rounding: 0x4001 -> 0x3C00 inexact (tie to even); 0x4003 -> 0x3C02 inexact.
REQ-032 SHALL check back-to-back stream of 8 operands with out_ready toggling 1-0-0-1: results in order, none lost or duplicated, outputs stable while stalled.
REQ-033 SHALL check rst_n asserted with 3 operands in flight: out_valid drops immediately, no stale result after release.

Source files
------------

// File: rtl/posit_fp_pkg.sv
// Shared helpers for the posit-to-float datapath: a constant-safe clog2,
// the bit positions of the result flags, and builders for the special
// floating-point encodings.
package posit_fp_pkg;

  localparam int FLAG_W       = 5;
  localparam int FLAG_NAR     = 4;
  localparam int FLAG_ZERO    = 3;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_UNF     = 1;
  localparam int FLAG_INEXACT = 0;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Canonical quiet NaN for an n-bit float with fe exponent bits:
  // positive sign, all-ones exponent, only the top mantissa bit set.
  function automatic logic [63:0] fp_qnan(input int n, input int fe);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < fe; b++) begin
      v[n-2-b] = 1'b1;
    end
    v[n-fe-2] = 1'b1;
    return v;
  endfunction

  // Signed infinity: all-ones exponent, zero mantissa.
  function automatic logic [63:0] fp_inf(input int n, input int fe, input logic sign);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < fe; b++) begin
      v[n-2-b] = 1'b1;
    end
    v[n-1] = sign;
    return v;
  endfunction

endpackage

// File: rtl/posit_decode.sv
// Combinational posit field decoder. Works on the magnitude body (sign
// already stripped) and returns the regime value k, the regime polarity,
// the exponent field and the fraction left-aligned with the hidden one
// implied above its MSB. Exponent bits cut off by a long regime read as 0.
module posit_decode import posit_fp_pkg::*; #(
  parameter int N  = 16,
  parameter int ES = 2,
  localparam int KW = clog2(N) + 1
) (
  input  logic [N-2:0]          i_body,
  output logic                  o_rsign,
  output logic signed [KW-1:0]  o_k,
  output logic [ES-1:0]         o_exp,
  output logic [N-2:0]          o_frac
);

  localparam int CW = clog2(N) + 1;

  logic [CW-1:0] w_run;
  logic          w_stop;
  logic [N-2:0]  w_rem;

  // Length of the run of bits equal to the leading regime bit.
  always_comb begin
    w_run  = '0;
    w_stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!w_stop && (i_body[i] == i_body[N-2])) begin
        w_run = w_run + CW'(1);
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  assign o_rsign = i_body[N-2];
  assign o_k     = o_rsign ? $signed(w_run - CW'(1)) : $signed(CW'(0) - w_run);
  assign w_rem   = i_body << (w_run + CW'(1));
  assign o_exp   = w_rem[N-2 -: ES];
  assign o_frac  = w_rem << ES;

endmodule

// File: rtl/posit_to_fp_pipe.sv
// Three-stage elastic pipeline converting an N-bit posit into an N-bit
// IEEE-style float with no subnormals. S1 decodes, S2 forms the biased
// exponent and splits the fraction into mantissa/guard/sticky, S3 rounds
// to nearest-even, range-checks and packs. Each stage may take new data
// whenever the stage after it is empty or emptying in the same cycle.
module posit_to_fp_pipe import posit_fp_pkg::*; #(
  parameter int N  = 16,
  parameter int ES = 2,
  parameter int FE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_posit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      out_fp,
  output logic [FLAG_W-1:0] out_flags,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int FM   = N - FE - 1;
  localparam int BW   = N - 1;
  localparam int KW   = clog2(N) + 1;
  localparam int SW   = ((FE > ES + clog2(N)) ? FE : ES + clog2(N)) + 2;
  localparam logic signed [SW-1:0] BIAS_S    = SW'(2**(FE-1) - 1);
  localparam logic signed [SW-1:0] EXP_MAX_S = SW'(2**FE - 1);
  localparam logic signed [SW-1:0] ZERO_S    = '0;
  localparam logic [N-1:0] QNAN    = N'(fp_qnan(N, FE));
  localparam logic [N-1:0] POS_INF = N'(fp_inf(N, FE, 1'b0));
  localparam logic [N-1:0] NEG_INF = N'(fp_inf(N, FE, 1'b1));

  logic w_load1, w_load2, w_load3;
  logic r_v1, r_v2, r_v3;

  logic                 w_sign, w_zero, w_nar, w_rsign;
  logic [BW-1:0]        w_body;
  logic signed [KW-1:0] w_k;
  logic [ES-1:0]        w_exp;
  logic [BW-1:0]        w_frac;

  logic                 r_s1_sign, r_s1_zero, r_s1_nar, r_s1_rsign;
  logic signed [KW-1:0] r_s1_k;
  logic [ES-1:0]        r_s1_exp;
  logic [BW-1:0]        r_s1_frac;

  logic signed [SW-1:0] w_scale, w_biased;

  logic                 r_s2_sign, r_s2_zero, r_s2_nar, r_s2_guard, r_s2_sticky;
  logic signed [SW-1:0] r_s2_exp;
  logic [FM-1:0]        r_s2_mant;

  logic                 w_rup, w_inexact;
  logic [FM:0]          w_mant_r;
  logic signed [SW-1:0] w_exp_r;
  logic [N-1:0]         w_fp;
  logic [FLAG_W-1:0]    w_flags;

  logic [N-1:0]         r_s3_fp;
  logic [FLAG_W-1:0]    r_s3_flags;

  // A stage loads when it is empty or its contents move on this cycle.
  assign w_load3  = ~r_v3 | out_ready;
  assign w_load2  = ~r_v2 | w_load3;
  assign w_load1  = ~r_v1 | w_load2;
  assign in_ready = w_load1;

  assign w_sign = in_posit[N-1];
  assign w_body = w_sign ? (~in_posit[N-2:0] + BW'(1)) : in_posit[N-2:0];
  assign w_zero = (in_posit == '0);
  assign w_nar  = (in_posit == {1'b1, {(N-1){1'b0}}});

  posit_decode #(.N(N), .ES(ES)) u_decode (
    .i_body  (w_body),
    .o_rsign (w_rsign),
    .o_k     (w_k),
    .o_exp   (w_exp),
    .o_frac  (w_frac)
  );

  // S1: capture sign, special-case detection and decoded posit fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_rsign <= 1'b0;
      r_s1_k     <= '0;
      r_s1_exp   <= '0;
      r_s1_frac  <= '0;
    end else if (w_load1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_sign  <= w_sign;
        r_s1_zero  <= w_zero;
        r_s1_nar   <= w_nar;
        r_s1_rsign <= w_rsign;
        r_s1_k     <= w_k;
        r_s1_exp   <= w_exp;
        r_s1_frac  <= w_frac;
      end
    end
  end

  // Scale k*2^ES + e is exactly k with e appended; the regime polarity
  // supplies the sign extension into the wider exponent arithmetic.
  assign w_scale  = {{(SW-KW-ES){~r_s1_rsign}}, r_s1_k, r_s1_exp};
  assign w_biased = w_scale + BIAS_S;

  // S2: biased exponent plus mantissa, guard bit and sticky OR of the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2        <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_nar    <= 1'b0;
      r_s2_exp    <= '0;
      r_s2_mant   <= '0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
    end else if (w_load2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_zero   <= r_s1_zero;
        r_s2_nar    <= r_s1_nar;
        r_s2_exp    <= w_biased;
        r_s2_mant   <= r_s1_frac[BW-1 -: FM];
        r_s2_guard  <= r_s1_frac[BW-1-FM];
        r_s2_sticky <= |r_s1_frac[BW-2-FM:0];
      end
    end
  end

  assign w_rup     = r_s2_guard & (r_s2_sticky | r_s2_mant[0]);
  assign w_mant_r  = {1'b0, r_s2_mant} + (FM+1)'(w_rup);
  assign w_exp_r   = r_s2_exp + $signed({{(SW-1){1'b0}}, w_mant_r[FM]});
  assign w_inexact = r_s2_guard | r_s2_sticky;

  // Round-to-nearest-even result with special values and range clamping.
  always_comb begin
    w_fp                  = {r_s2_sign, w_exp_r[FE-1:0], w_mant_r[FM-1:0]};
    w_flags               = '0;
    w_flags[FLAG_INEXACT] = w_inexact;
    if (r_s2_nar) begin
      w_fp              = QNAN;
      w_flags           = '0;
      w_flags[FLAG_NAR] = 1'b1;
    end else if (r_s2_zero) begin
      w_fp               = '0;
      w_flags            = '0;
      w_flags[FLAG_ZERO] = 1'b1;
    end else if (w_exp_r >= EXP_MAX_S) begin
      w_fp                  = r_s2_sign ? NEG_INF : POS_INF;
      w_flags               = '0;
      w_flags[FLAG_OVF]     = 1'b1;
      w_flags[FLAG_INEXACT] = 1'b1;
    end else if (w_exp_r <= ZERO_S) begin
      w_fp                  = {r_s2_sign, {(N-1){1'b0}}};
      w_flags               = '0;
      w_flags[FLAG_UNF]     = 1'b1;
      w_flags[FLAG_INEXACT] = 1'b1;
    end
  end

  // S3: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3       <= 1'b0;
      r_s3_fp    <= '0;
      r_s3_flags <= '0;
    end else if (w_load3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_s3_fp    <= w_fp;
        r_s3_flags <= w_flags;
      end
    end
  end

  assign out_fp    = r_s3_fp;
  assign out_flags = r_s3_flags;
  assign out_valid = r_v3;

endmodule

// File: tb/tb_posit_to_fp_pipe.sv
// Bench for posit_to_fp_pipe with N=16, ES=2, FE=5. Expected results come
// from a bit-walking posit reader that rounds with integer arithmetic.
module tb_posit_to_fp_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_posit;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_fp;
  logic [4:0]  out_flags;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  posit_to_fp_pipe #(.N(16), .ES(2), .FE(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_posit  (in_posit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_fp    (out_fp),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference conversion returning {flags, fp}.
  function automatic logic [20:0] ref_convert(input logic [15:0] p);
    int m, i, run, k, e, nf, fval, scale, mant, d, remd, half, be;
    bit s, r, inex;
    logic [15:0] fp;
    logic [4:0]  fl;
    if (p == 16'h0000) return {5'b01000, 16'h0000};
    if (p == 16'h8000) return {5'b10000, 16'h7E00};
    s = p[15];
    m = s ? (65536 - int'(p)) : int'(p);
    r = bit'((m >> 14) & 1);
    i = 14;
    run = 0;
    while (i >= 0 && (((m >> i) & 1) == int'(r))) begin
      run++;
      i--;
    end
    k = r ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2;
      if (i >= 0) begin
        e += (m >> i) & 1;
        i--;
      end
    end
    nf = (i >= 0) ? i + 1 : 0;
    fval = m & ((1 << nf) - 1);
    scale = k * 4 + e;
    inex = 1'b0;
    if (nf <= 10) begin
      mant = fval << (10 - nf);
    end else begin
      d = nf - 10;
      mant = fval >> d;
      remd = fval & ((1 << d) - 1);
      half = 1 << (d - 1);
      if (remd > half || (remd == half && (mant & 1) == 1)) mant++;
      inex = (remd != 0);
    end
    if (mant == 1024) begin
      mant = 0;
      scale++;
    end
    be = scale + 15;
    if (be >= 31) begin
      fp = {s, 5'h1F, 10'h000};
      fl = 5'b00101;
    end else if (be <= 0) begin
      fp = {s, 15'h0000};
      fl = 5'b00011;
    end else begin
      fp = {s, 5'(be), 10'(mant)};
      fl = {4'b0000, inex};
    end
    return {fl, fp};
  endfunction

  // Random operand biased toward special and extreme encodings.
  function automatic logic [15:0] rand_posit();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF - 16'($urandom_range(0, 7));
      3: return 16'h0001 + 16'($urandom_range(0, 7));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_posit  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_fp !== 16'h0000) begin bad++; $display("FAIL reset_out_fp got=%h want=0000", out_fp); end
    total++; if (out_flags !== 5'b00000) begin bad++; $display("FAIL reset_out_flags got=%b want=00000", out_flags); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] vin [8];
    logic [15:0] vfp [8];
    logic [4:0]  vfl [8];
    vin = '{16'h4000, 16'hC000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'h4001, 16'h4003};
    vfp = '{16'h3C00, 16'hBC00, 16'h0000, 16'h7E00, 16'h7C00, 16'h0000, 16'h3C00, 16'h3C02};
    vfl = '{5'b00000, 5'b00000, 5'b01000, 5'b10000, 5'b00101, 5'b00011, 5'b00001, 5'b00001};
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      in_posit  = vin[n];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir_in_ready[%0d] got=%b want=1", n, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_early1[%0d] got=%b want=0", n, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir_early2[%0d] got=%b want=0", n, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir_valid[%0d] got=%b want=1", n, out_valid); end
      total++; if (out_fp !== vfp[n]) begin bad++; $display("FAIL dir_fp[%0d] in=%h got=%h want=%h", n, vin[n], out_fp, vfp[n]); end
      total++; if (out_flags !== vfl[n]) begin bad++; $display("FAIL dir_flags[%0d] in=%h got=%b want=%b", n, vin[n], out_flags, vfl[n]); end
    end
  endtask

  task automatic test_random();
    logic [20:0] expq [$];
    logic [20:0] want;
    logic [15:0] hold_fp;
    logic [4:0]  hold_fl;
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 1'b0;
    while (got < 60 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_fp !== hold_fp || out_flags !== hold_fl) begin
          bad++; $display("FAIL rnd_stall_hold got=%b/%h/%b want=1/%h/%b", out_valid, out_fp, out_flags, hold_fp, hold_fl);
        end
      end
      in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
      in_posit  = rand_posit();
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(ref_convert(in_posit));
        sent++;
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          total++;
          if (expq.size() == 0) begin
            bad++; $display("FAIL rnd_extra got=%h/%b want=none", out_fp, out_flags);
          end else begin
            want = expq.pop_front();
            if ({out_flags, out_fp} !== want) begin
              bad++; $display("FAIL rnd_result[%0d] got=%h/%b want=%h/%b", got, out_fp, out_flags, want[15:0], want[20:16]);
            end
          end
          got++;
        end else begin
          stalled = 1'b1;
          hold_fp = out_fp;
          hold_fl = out_flags;
        end
      end
    end
    in_valid = 1'b0;
    total++; if (got != 60) begin bad++; $display("FAIL rnd_timeout got=%0d want=60", got); end
  endtask

  task automatic test_back_to_back();
    logic [20:0] expq [$];
    logic [20:0] want;
    logic [15:0] hold_fp;
    logic [4:0]  hold_fl;
    bit pat [4];
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_fp !== hold_fp || out_flags !== hold_fl) begin
          bad++; $display("FAIL b2b_stall_hold got=%b/%h/%b want=1/%h/%b", out_valid, out_fp, out_flags, hold_fp, hold_fl);
        end
      end
      in_valid  = (sent < 8);
      in_posit  = rand_posit();
      out_ready = pat[cyc % 4];
      cyc++;
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(ref_convert(in_posit));
        sent++;
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          total++;
          if (expq.size() == 0) begin
            bad++; $display("FAIL b2b_extra got=%h want=none", out_fp);
          end else begin
            want = expq.pop_front();
            if ({out_flags, out_fp} !== want) begin
              bad++; $display("FAIL b2b_result[%0d] got=%h/%b want=%h/%b", got, out_fp, out_flags, want[15:0], want[20:16]);
            end
          end
          got++;
        end else begin
          stalled = 1'b1;
          hold_fp = out_fp;
          hold_fl = out_flags;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
    repeat (5) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [20:0] want;
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_posit = rand_posit();
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_full got=%b want=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_drop got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    total++; if (out_fp !== 16'h0000 || out_flags !== 5'b00000) begin bad++; $display("FAIL mid_clear got=%h/%b want=0000/00000", out_fp, out_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
    in_posit = rand_posit();
    in_valid = 1'b1;
    want = ref_convert(in_posit);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_early got=%b want=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_latency got=%b want=1", out_valid); end
    total++; if ({out_flags, out_fp} !== want) begin bad++; $display("FAIL mid_result got=%h/%b want=%h/%b", out_fp, out_flags, want[15:0], want[20:16]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Last-resort guard so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog time=%0t limit=400000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
